// File: rtl/mmio_store_responder_pkg.sv
// Shared register offsets and bit positions for the MMIO store responder.
package mmio_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    localparam int unsigned ST_EMPTY = 16;
    localparam int unsigned ST_FULL  = 17;
    localparam int unsigned ST_OVF   = 18;

    localparam int unsigned CTRL_CLR_OVF = 0;
    localparam int unsigned CTRL_FLUSH   = 1;

endpackage

// File: rtl/mmio_store_responder_sync_fifo.sv
// First-word-fall-through FIFO with push/pop/flush; flush takes priority over everything.
module sync_fifo #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [N-1:0]  wdata,
    output logic [N-1:0]  head,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + (AW+1)'(1);
            else if (pop && !push) count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= wdata;
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/mmio_store_responder.sv
// CPU-bus store responder: decodes a 3-register window, queues TXDATA stores into a FIFO.
module mmio_store_responder
    import mmio_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter logic [N-1:0] BASE = 32'h0000_0100,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memwrite,
    input  logic [N-1:0] dataadr,
    input  logic [N-1:0] writedata,
    output logic [N-1:0] readdata,
    output logic         hit,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready,
    output logic         overflow
);

    logic          sel_tx, sel_status, sel_ctrl;
    logic          push, pop, flush, clr_ovf, drop;
    logic [N-1:0]  head;
    logic [AW:0]   count;
    logic          empty, full;
    logic [N-1:0]  status;
    logic          overflow_q, overflow_d;

    // Exact-match compares imply word alignment since BASE is word-aligned.
    assign sel_tx     = (dataadr == BASE + N'(OFF_TXDATA));
    assign sel_status = (dataadr == BASE + N'(OFF_STATUS));
    assign sel_ctrl   = (dataadr == BASE + N'(OFF_CTRL));
    assign hit        = sel_tx | sel_status | sel_ctrl;

    assign pop     = out_valid & out_ready;
    assign push    = memwrite & sel_tx & (~full | pop);
    assign drop    = memwrite & sel_tx & full & ~pop;
    assign flush   = memwrite & sel_ctrl & writedata[CTRL_FLUSH];
    assign clr_ovf = memwrite & sel_ctrl & writedata[CTRL_CLR_OVF];

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (writedata),
        .head  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (clr_ovf)   overflow_d = 1'b0;
        else if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    always_comb begin
        status            = '0;
        status[AW:0]      = count;
        status[ST_EMPTY]  = empty;
        status[ST_FULL]   = full;
        status[ST_OVF]    = overflow_q;
    end

    always_comb begin
        readdata = '0;
        if (sel_tx && !empty) readdata = head;
        else if (sel_status)  readdata = status;
    end

    assign out_valid = ~empty;
    assign out_data  = head;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mmio_store_responder.sv
// Randomised + directed bench with a queue model and a scoreboard-driven drain monitor.
module tb_mmio_store_responder;

    localparam int unsigned N     = 32;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        hit;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    logic [31:0] mq[$];     // reference FIFO contents
    logic [31:0] exp_q[$];  // scoreboard of words expected at the output
    logic        movf = 1'b0;

    mmio_store_responder #(
        .N     (N),
        .BASE  (BASE),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .hit       (hit),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(mq.size());
        if (mq.size() == 0)     s = s + 32'h0001_0000;
        if (mq.size() == DEPTH) s = s + 32'h0002_0000;
        if (movf)               s = s + 32'h0004_0000;
        return s;
    endfunction

    // Monitor: every accepted output word must match the scoreboard head.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("drain_unexpected", out_data, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("drain", out_data, e);
                end
            end
        end
    end

    // One bus cycle; entered and left 1 time unit after a rising edge.
    task automatic cycle(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                         input logic rdy);
        logic pop, push_ok, flush;
        logic [31:0] exp_rd;
        memwrite  = we;
        dataadr   = adr;
        writedata = wd;
        out_ready = rdy;
        @(negedge clk);
        exp_rd = 32'h0;
        if (adr == BASE && mq.size() != 0) exp_rd = mq[0];
        else if (adr == BASE + 4)          exp_rd = model_status();
        check("readdata", readdata, exp_rd);
        check("hit", {31'b0, hit}, {31'b0, adr == BASE || adr == BASE + 4 || adr == BASE + 8});
        check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
        check("overflow", {31'b0, overflow}, {31'b0, movf});
        if (mq.size() != 0) check("out_data", out_data, mq[0]);
        @(posedge clk);
        pop     = (mq.size() != 0) && rdy;
        flush   = we && adr == BASE + 8 && wd[1];
        push_ok = we && adr == BASE && (mq.size() < DEPTH || pop);
        if (we && adr == BASE + 8 && wd[0]) movf = 1'b0;
        if (we && adr == BASE && !push_ok)  movf = 1'b1;
        if (flush) begin
            mq.delete();
            exp_q.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push_ok) begin
                mq.push_back(wd);
                exp_q.push_back(wd);
            end
        end
        #1;
    endtask

    task automatic store(input logic [31:0] wd, input logic rdy);
        cycle(1'b1, BASE, wd, rdy);
    endtask

    task automatic load_status(input logic rdy);
        cycle(1'b0, BASE + 4, 32'h0, rdy);
    endtask

    task automatic drain_all();
        for (int i = 0; i < DEPTH + 2; i++) load_status(1'b1);
    endtask

    initial begin
        logic [31:0] adr, wd;
        int sel;

        // Reset held for two cycles, released away from the edge.
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        load_status(1'b0);
        check("reset_status_const", readdata, 32'h0001_0000);

        // Single store, then drain.
        store(32'h96, 1'b0);
        load_status(1'b0);
        check("status_one", readdata, 32'h0000_0001);
        load_status(1'b1);
        load_status(1'b0);
        check("status_empty", readdata, 32'h0001_0000);

        // Fill, overflow, drain, clear.
        for (int i = 1; i <= 8; i++) store(32'(i), 1'b0);
        load_status(1'b0);
        check("status_full", readdata, 32'h0002_0008);
        store(32'd9, 1'b0);
        load_status(1'b0);
        check("status_ovf", readdata, 32'h0006_0008);
        drain_all();
        cycle(1'b1, BASE + 8, 32'h1, 1'b0);

        // Full with simultaneous push and pop.
        for (int i = 1; i <= 8; i++) store(32'(i + 16), 1'b0);
        store(32'hA, 1'b1);
        load_status(1'b0);
        check("full_pushpop", readdata, 32'h0002_0008);
        drain_all();

        // Flush beats a same-cycle pop; misses have no side effects.
        for (int i = 0; i < 3; i++) store(32'(i + 32'h40), 1'b0);
        cycle(1'b1, BASE + 8, 32'h2, 1'b1);
        load_status(1'b0);
        check("after_flush", readdata, 32'h0001_0000);
        cycle(1'b1, BASE + 12, 32'h77, 1'b0);
        cycle(1'b1, BASE + 2, 32'h78, 1'b0);
        cycle(1'b1, BASE + 4, 32'h79, 1'b0);
        load_status(1'b0);

        // Asynchronous reset mid-drain discards the queue.
        for (int i = 0; i < 5; i++) store(32'(i + 32'h80), 1'b0);
        for (int i = 0; i < 3; i++) load_status(i[0] == 1'b0);
        memwrite = 1'b0;
        dataadr  = BASE + 4;
        out_ready = 1'b1;
        #3 reset = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_status", readdata, 32'h0001_0000);
        mq.delete();
        exp_q.delete();
        movf = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        store(32'h55, 1'b0);
        check("first_after_reset", exp_q.size() > 0 ? exp_q[0] : 32'h0, 32'h55);
        drain_all();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: adr = BASE;
                4, 5:       adr = BASE + 4;
                6:          adr = BASE + 8;
                7:          adr = BASE + 12;
                8:          adr = BASE + 2;
                default:    adr = $urandom;
            endcase
            wd = $urandom;
            if (adr == BASE + 8)
                wd = {30'b0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1))};
            cycle($urandom_range(0, 9) < 6, adr, wd, 1'($urandom_range(0, 1)));
        end
        drain_all();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
